// File: rtl/mmu_encoder_if.sv
// Handshake bundle between a burst requester, the MMU encoder and the
// instruction consumer. The encoder sits on the slave side; the requester
// and the consumer together form the master side.
interface mmu_encoder_if;
    // Burst request channel
    logic       req_valid;
    logic       req_ready;
    logic       req_ld;
    logic [3:0] req_reg;
    logic [3:0] req_mem;
    logic [3:0] req_sel;
    logic [3:0] req_count;

    // Instruction output channel
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_last;

    modport slave (
        input  req_valid, req_ld, req_reg, req_mem, req_sel, req_count,
        output req_ready,
        output instr_valid, instr, instr_last,
        input  instr_ready
    );

    modport master (
        output req_valid, req_ld, req_reg, req_mem, req_sel, req_count,
        input  req_ready,
        input  instr_valid, instr, instr_last,
        output instr_ready
    );
endinterface

// File: rtl/mmu_encoder.sv
// MMU instruction encoder: expands a load/store burst request into a stream
// of single 32-bit MMU instruction words, incrementing the register and
// memory-location addresses by one per word (modulo 16).
module mmu_encoder #(
    parameter logic [1:0] OPCODE = 2'b00
) (
    input  logic          clk,
    input  logic          rst,
    mmu_encoder_if.slave  bus,
    output logic          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        ld_q,    ld_d;
    logic [3:0]  reg_q,   reg_d;
    logic [3:0]  mem_q,   mem_d;
    logic [3:0]  sel_q,   sel_d;
    logic [3:0]  rem_q,   rem_d;
    logic        req_ready;
    logic        accept;
    logic        advance;

    // Word layout: opcode | st | ld | reg | mem | sel | zero padding.
    // st is always the complement of ld, so exactly one of them is set.
    function automatic logic [31:0] encode(input logic       ld,
                                           input logic [3:0] r,
                                           input logic [3:0] m,
                                           input logic [3:0] s);
        return {OPCODE, ~ld, ld, r, m, s, 16'h0000};
    endfunction

    // Ready depends only on state and reset, never on the other handshakes.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = bus.req_valid && req_ready;
    assign advance   = valid_q && bus.instr_ready;

    assign bus.req_ready   = req_ready;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_last  = valid_q && (rem_q == 4'd0);
    assign busy            = (state_q == EMIT);

    // Next-state and next-word computation for the IDLE/EMIT sequencer.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        ld_d    = ld_q;
        reg_d   = reg_q;
        mem_d   = mem_q;
        sel_d   = sel_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                    ld_d    = bus.req_ld;
                    reg_d   = bus.req_reg;
                    mem_d   = bus.req_mem;
                    sel_d   = bus.req_sel;
                    rem_d   = bus.req_count;
                    instr_d = encode(bus.req_ld, bus.req_reg, bus.req_mem, bus.req_sel);
                end
            end
            EMIT: begin
                // Nothing moves until the consumer takes the current word.
                if (advance) begin
                    if (rem_q == 4'd0) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        instr_d = 32'h0000_0000;
                    end else begin
                        reg_d   = reg_q + 4'd1;
                        mem_d   = mem_q + 4'd1;
                        rem_d   = rem_q - 4'd1;
                        instr_d = encode(ld_q, reg_q + 4'd1, mem_q + 4'd1, sel_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                instr_d = 32'h0000_0000;
            end
        endcase
    end

    // State register with synchronous reset; a reset mid-burst discards it.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            instr_q <= 32'h0000_0000;
            valid_q <= 1'b0;
            ld_q    <= 1'b0;
            reg_q   <= 4'd0;
            mem_q   <= 4'd0;
            sel_q   <= 4'd0;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ld_q    <= ld_d;
            reg_q   <= reg_d;
            mem_q   <= mem_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
        end
    end

endmodule
